// File: rtl/vga_scanout.sv
// VGA timing generator and latency-matched framebuffer scanout with centred, scaled window.
// Optional colour-bar test pattern is compiled in with `define VGA_TESTPAT_EN.
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 40,
    parameter int H_TOTAL    = 832,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 9,
    parameter int V_SYNC     = 2,
    parameter int V_TOTAL    = 520,
    parameter int WIN_W      = 256,
    parameter int WIN_H      = 256,
    parameter int SCALE_LOG2 = 0,
    parameter int PIX_BITS   = 3,
    parameter int COLOR_BITS = 4,
    parameter int RAM_LAT    = 1,
    parameter int ADDR_W     = 17,
    parameter int SYNC_ACT   = 0
) (
    input  logic                  CLK,
    input  logic                  I_RESET_N,
    input  logic [PIX_BITS-1:0]   I_BORDER,
`ifdef VGA_TESTPAT_EN
    input  logic                  I_TESTPAT,
`endif
    output logic [ADDR_W-1:0]     O_VRAM_ADDR,
    input  logic [PIX_BITS-1:0]   I_VRAM_DATA,
    output logic                  O_HSYNC,
    output logic                  O_VSYNC,
    output logic [COLOR_BITS-1:0] O_VIDEO_R,
    output logic [COLOR_BITS-1:0] O_VIDEO_G,
    output logic [COLOR_BITS-1:0] O_VIDEO_B,
    output logic                  O_FRAME_START,
    output logic                  O_VBLANK
);

    localparam int WW    = WIN_W << SCALE_LOG2;
    localparam int WH    = WIN_H << SCALE_LOG2;
    localparam int LEFT  = (H_ACTIVE - WW) / 2;
    localparam int TOP   = (V_ACTIVE - WH) / 2;
    localparam int C     = PIX_BITS / 3;
    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int DEPTH = RAM_LAT + 1;
    localparam logic SYNC_ON = (SYNC_ACT != 0);

    if (WW > H_ACTIVE || WH > V_ACTIVE) begin : g_bad_window
        $error("vga_scanout: scaled window does not fit the active area");
    end
    if (PIX_BITS % 3 != 0 || PIX_BITS == 0) begin : g_bad_pix
        $error("vga_scanout: PIX_BITS must be a non-zero multiple of 3");
    end
    if (RAM_LAT < 1 || RAM_LAT > 3 || SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_cfg
        $error("vga_scanout: RAM_LAT or SCALE_LOG2 out of range");
    end

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       win;
        logic       fs;
        logic       vb;
`ifdef VGA_TESTPAT_EN
        logic [2:0] bar;
`endif
    } ctl_t;

    logic [HW-1:0]         pixel_q, pixel_d;
    logic [VW-1:0]         line_q, line_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [PIX_BITS-1:0]   border_q;
    ctl_t                  ctl_s0;
    ctl_t                  tail;
    ctl_t                  pipe_q [DEPTH];
    logic [PIX_BITS-1:0]   pix;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  fs_q, vb_q;
    logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
`ifdef VGA_TESTPAT_EN
    logic                  testpat_q;
`endif

    // Repeat the channel pattern MSB-first until the DAC width is filled.
    function automatic logic [COLOR_BITS-1:0] expand(input logic [C-1:0] ch);
        logic [COLOR_BITS-1:0] e;
        for (int i = 0; i < COLOR_BITS; i++) begin
            e[COLOR_BITS-1-i] = ch[C-1-(i % C)];
        end
        return e;
    endfunction

    always_comb begin
        int px;
        int ln;
        px       = int'(pixel_q);
        ln       = int'(line_q);
        pixel_d  = (px == H_TOTAL - 1) ? '0 : pixel_q + 1'b1;
        line_d   = line_q;
        if (px == H_TOTAL - 1) begin
            line_d = (ln == V_TOTAL - 1) ? '0 : line_q + 1'b1;
        end
        ctl_s0     = '0;
        ctl_s0.hs  = (px >= H_ACTIVE + H_FP) && (px <= H_ACTIVE + H_FP + H_SYNC - 1);
        ctl_s0.vs  = (ln >= V_ACTIVE + V_FP) && (ln <= V_ACTIVE + V_FP + V_SYNC - 1);
        ctl_s0.act = (px < H_ACTIVE) && (ln < V_ACTIVE);
        ctl_s0.win = (px >= LEFT) && (px < LEFT + WW) && (ln >= TOP) && (ln < TOP + WH);
        ctl_s0.fs  = (px == 0) && (ln == 0);
        ctl_s0.vb  = (ln >= V_ACTIVE);
`ifdef VGA_TESTPAT_EN
        ctl_s0.bar = 3'(px / (H_ACTIVE / 8));
`endif
        addr_d = '0;
        if (ctl_s0.win) begin
            addr_d = ADDR_W'(((ln - TOP) >> SCALE_LOG2) * WIN_W + ((px - LEFT) >> SCALE_LOG2));
        end
    end

    // The tail of the shift register lines up with the vram data for the same position.
    always_comb begin
        tail    = pipe_q[DEPTH-1];
        hsync_d = tail.hs ? SYNC_ON : !SYNC_ON;
        vsync_d = tail.vs ? SYNC_ON : !SYNC_ON;
        pix     = '0;
        if (tail.act) begin
            pix = tail.win ? I_VRAM_DATA : border_q;
        end
        r_d = expand(pix[C-1:0]);
        b_d = expand(pix[2*C-1:C]);
        g_d = expand(pix[3*C-1:2*C]);
`ifdef VGA_TESTPAT_EN
        if (testpat_q && tail.act) begin
            r_d = {COLOR_BITS{tail.bar[0]}};
            b_d = {COLOR_BITS{tail.bar[1]}};
            g_d = {COLOR_BITS{tail.bar[2]}};
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!I_RESET_N) begin
            pixel_q  <= '0;
            line_q   <= '0;
            addr_q   <= '0;
            border_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
            hsync_q  <= !SYNC_ON;
            vsync_q  <= !SYNC_ON;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            fs_q     <= 1'b0;
            vb_q     <= 1'b0;
`ifdef VGA_TESTPAT_EN
            testpat_q <= 1'b0;
`endif
        end else begin
            pixel_q <= pixel_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            if (ctl_s0.fs) begin
                border_q <= I_BORDER;
`ifdef VGA_TESTPAT_EN
                testpat_q <= I_TESTPAT;
`endif
            end
            pipe_q[0] <= ctl_s0;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            fs_q    <= tail.fs;
            vb_q    <= tail.vb;
        end
    end

    assign O_VRAM_ADDR   = addr_q;
    assign O_HSYNC       = hsync_q;
    assign O_VSYNC       = vsync_q;
    assign O_VIDEO_R     = r_q;
    assign O_VIDEO_G     = g_q;
    assign O_VIDEO_B     = b_q;
    assign O_FRAME_START = fs_q;
    assign O_VBLANK      = vb_q;

endmodule
